// File: rtl/class_descriptor_reader.sv
// Class descriptor table with a query port that streams one class's
// header beat followed by its field-name tokens over a valid/ready link.
module class_descriptor_reader #(
  parameter int NUM_CLASSES = 4,
  parameter int MAX_FIELDS  = 8,
  parameter int NAME_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_en,
  input  logic [7:0]        wr_class,
  input  logic [7:0]        wr_field,
  input  logic [NAME_W-1:0] wr_name,
  input  logic              cnt_wr_en,
  input  logic [7:0]        cnt_wr_val,
  input  logic              q_valid,
  output logic              q_ready,
  input  logic [7:0]        q_class,
  output logic              r_valid,
  input  logic              r_ready,
  output logic              r_kind,
  output logic [NAME_W-1:0] r_data,
  output logic              r_last,
  output logic              r_error
);

  localparam int CW = (NUM_CLASSES > 1) ? $clog2(NUM_CLASSES) : 1;
  localparam int FW = (MAX_FIELDS > 1) ? $clog2(MAX_FIELDS) : 1;
  localparam logic [7:0] NC8 = 8'(NUM_CLASSES);
  localparam logic [7:0] MF8 = 8'(MAX_FIELDS);
  localparam logic [FW-1:0] F0 = '0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_HEADER,
    S_FIELDS
  } state_t;

  state_t r_state, w_state_nx;

  logic [7:0]        r_count [NUM_CLASSES];
  logic [NAME_W-1:0] r_name  [NUM_CLASSES][MAX_FIELDS];

  logic [CW-1:0]     r_cls, w_cls_nx;
  logic [7:0]        r_cnt, w_cnt_nx;
  logic [7:0]        r_idx, w_idx_nx;
  logic              r_vld, w_vld_nx;
  logic              r_knd, w_knd_nx;
  logic              r_lst, w_lst_nx;
  logic              r_err, w_err_nx;
  logic [NAME_W-1:0] r_dat, w_dat_nx;

  logic [CW-1:0] w_wc;
  logic [FW-1:0] w_wf;
  logic [CW-1:0] w_qc;
  logic [7:0]    w_nx_idx;
  logic [7:0]    w_sat;
  logic          w_wr_ok;
  logic          w_cnt_ok;
  logic          w_q_ok;

  assign w_wc     = wr_class[CW-1:0];
  assign w_wf     = wr_field[FW-1:0];
  assign w_qc     = q_class[CW-1:0];
  assign w_nx_idx = r_idx + 8'd1;
  assign w_sat    = (cnt_wr_val > MF8) ? MF8 : cnt_wr_val;
  assign w_wr_ok  = (wr_class < NC8) && (wr_field < MF8);
  assign w_cnt_ok = (wr_class < NC8);
  assign w_q_ok   = (q_class < NC8);

  always_comb begin
    w_state_nx = r_state;
    w_cls_nx   = r_cls;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_vld_nx   = r_vld;
    w_knd_nx   = r_knd;
    w_lst_nx   = r_lst;
    w_err_nx   = r_err;
    w_dat_nx   = r_dat;
    unique case (r_state)
      S_IDLE: begin
        if (q_valid) begin
          w_state_nx = S_HEADER;
          w_vld_nx   = 1'b1;
          w_knd_nx   = 1'b0;
          w_idx_nx   = 8'd0;
          if (w_q_ok) begin
            w_cls_nx = w_qc;
            w_cnt_nx = r_count[w_qc];
            w_dat_nx = NAME_W'(r_count[w_qc]);
            w_lst_nx = (r_count[w_qc] == 8'd0);
            w_err_nx = 1'b0;
          end else begin
            w_cls_nx = '0;
            w_cnt_nx = 8'd0;
            w_dat_nx = '0;
            w_lst_nx = 1'b1;
            w_err_nx = 1'b1;
          end
        end
      end
      S_HEADER, S_FIELDS: begin
        if (r_ready) begin
          if (r_lst) begin
            w_state_nx = S_IDLE;
            w_vld_nx   = 1'b0;
            w_knd_nx   = 1'b0;
            w_lst_nx   = 1'b0;
            w_err_nx   = 1'b0;
            w_dat_nx   = '0;
          end else if (r_state == S_HEADER) begin
            w_state_nx = S_FIELDS;
            w_knd_nx   = 1'b1;
            w_err_nx   = 1'b0;
            w_idx_nx   = 8'd0;
            w_dat_nx   = r_name[r_cls][F0];
            w_lst_nx   = (r_cnt == 8'd1);
          end else begin
            w_idx_nx = w_nx_idx;
            w_dat_nx = r_name[r_cls][w_nx_idx[FW-1:0]];
            w_lst_nx = (w_nx_idx == r_cnt - 8'd1);
          end
        end
      end
      default: w_state_nx = S_IDLE;
    endcase
  end

  // Table updates sit beside the stream regs so reads above see old data
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cls   <= '0;
      r_cnt   <= 8'd0;
      r_idx   <= 8'd0;
      r_vld   <= 1'b0;
      r_knd   <= 1'b0;
      r_lst   <= 1'b0;
      r_err   <= 1'b0;
      r_dat   <= '0;
      for (int c = 0; c < NUM_CLASSES; c++) begin
        r_count[c] <= 8'd0;
        for (int f = 0; f < MAX_FIELDS; f++) r_name[c][f] <= '0;
      end
    end else begin
      r_state <= w_state_nx;
      r_cls   <= w_cls_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_vld   <= w_vld_nx;
      r_knd   <= w_knd_nx;
      r_lst   <= w_lst_nx;
      r_err   <= w_err_nx;
      r_dat   <= w_dat_nx;
      if (wr_en && w_wr_ok) r_name[w_wc][w_wf] <= wr_name;
      if (cnt_wr_en && w_cnt_ok) r_count[w_wc] <= w_sat;
    end
  end

  assign q_ready = (r_state == S_IDLE);
  assign r_valid = r_vld;
  assign r_kind  = r_knd;
  assign r_data  = r_dat;
  assign r_last  = r_lst;
  assign r_error = r_err;

endmodule

// File: tb/tb_class_descriptor_reader.sv
// Bench for class_descriptor_reader: directed scenarios plus random
// traffic checked against a table-and-queue reference model.
module tb_class_descriptor_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_en;
  logic [7:0]  wr_class;
  logic [7:0]  wr_field;
  logic [31:0] wr_name;
  logic        cnt_wr_en;
  logic [7:0]  cnt_wr_val;
  logic        q_valid;
  logic        q_ready;
  logic [7:0]  q_class;
  logic        r_valid;
  logic        r_ready;
  logic        r_kind;
  logic [31:0] r_data;
  logic        r_last;
  logic        r_error;

  always #5 clk = ~clk;

  class_descriptor_reader #(
    .NUM_CLASSES(4),
    .MAX_FIELDS(8),
    .NAME_W(32)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .wr_en(wr_en),
    .wr_class(wr_class),
    .wr_field(wr_field),
    .wr_name(wr_name),
    .cnt_wr_en(cnt_wr_en),
    .cnt_wr_val(cnt_wr_val),
    .q_valid(q_valid),
    .q_ready(q_ready),
    .q_class(q_class),
    .r_valid(r_valid),
    .r_ready(r_ready),
    .r_kind(r_kind),
    .r_data(r_data),
    .r_last(r_last),
    .r_error(r_error)
  );

  typedef struct packed {
    logic        k;
    logic [31:0] d;
    logic        l;
    logic        e;
  } beat_t;

  int          checks = 0;
  int          errors = 0;
  int          cnt_m [4];
  logic [31:0] name_m [4][8];
  beat_t       exp_q [$];

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    for (int c = 0; c < 4; c++) begin
      cnt_m[c] = 0;
      for (int f = 0; f < 8; f++) name_m[c][f] = '0;
    end
  endtask

  task automatic set_name(input int c, input int f, input logic [31:0] n);
    if (c < 4 && f < 8) name_m[c][f] = n;
  endtask

  task automatic set_cnt(input int c, input int v);
    if (c < 4) cnt_m[c] = (v > 8) ? 8 : v;
  endtask

  task automatic do_write(input int c, input int f, input logic [31:0] n);
    wr_en = 1'b1;
    wr_class = 8'(c);
    wr_field = 8'(f);
    wr_name = n;
    @(negedge clk);
    wr_en = 1'b0;
    set_name(c, f, n);
  endtask

  task automatic do_count(input int c, input int v);
    cnt_wr_en = 1'b1;
    wr_class = 8'(c);
    cnt_wr_val = 8'(v);
    @(negedge clk);
    cnt_wr_en = 1'b0;
    set_cnt(c, v);
  endtask

  task automatic build_exp(input int c);
    int n;
    exp_q.delete();
    if (c >= 4) begin
      exp_q.push_back('{k: 1'b0, d: 32'd0, l: 1'b1, e: 1'b1});
    end else begin
      n = cnt_m[c];
      exp_q.push_back('{k: 1'b0, d: 32'(n), l: (n == 0), e: 1'b0});
      for (int i = 0; i < n; i++)
        exp_q.push_back('{k: 1'b1, d: name_m[c][i], l: (i == n - 1), e: 1'b0});
    end
  endtask

  // mode 0: ready high, 1: ready 1,0,0 repeating, 2: random ready
  task automatic query(input int c, input int mode, input int inj_k);
    int    k;
    int    cyc;
    logic  rdy;
    beat_t b;
    build_exp(c);
    chk("q_ready_idle", 32'(q_ready), 32'd1);
    q_valid = 1'b1;
    q_class = 8'(c);
    @(negedge clk);
    q_valid = 1'b0;
    k = 0;
    cyc = 0;
    while (k < exp_q.size() && cyc < 200) begin
      b = exp_q[k];
      chk("r_valid", 32'(r_valid), 32'd1);
      chk("q_ready_busy", 32'(q_ready), 32'd0);
      chk("r_kind", 32'(r_kind), 32'(b.k));
      chk("r_data", r_data, b.d);
      chk("r_last", 32'(r_last), 32'(b.l));
      chk("r_error", 32'(r_error), 32'(b.e));
      case (mode)
        0: rdy = 1'b1;
        1: rdy = ((cyc % 3) == 0);
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      r_ready = rdy;
      if (rdy && k == inj_k) begin
        wr_en = 1'b1;
        wr_class = 8'd1;
        wr_field = 8'd2;
        wr_name = 32'hFF;
        cnt_wr_en = 1'b1;
        cnt_wr_val = 8'd1;
        set_name(1, 2, 32'hFF);
        set_cnt(1, 1);
      end
      @(negedge clk);
      wr_en = 1'b0;
      cnt_wr_en = 1'b0;
      r_ready = 1'b0;
      if (rdy) k++;
      cyc++;
    end
    if (k < exp_q.size()) chk("stream_timeout", 32'(k), 32'(exp_q.size()));
    chk("r_valid_done", 32'(r_valid), 32'd0);
    chk("q_ready_done", 32'(q_ready), 32'd1);
  endtask

  initial begin
    rst_n = 1'b0;
    wr_en = 1'b0;
    wr_class = '0;
    wr_field = '0;
    wr_name = '0;
    cnt_wr_en = 1'b0;
    cnt_wr_val = '0;
    q_valid = 1'b0;
    q_class = '0;
    r_ready = 1'b0;
    model_clear();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    chk("rst_r_valid", 32'(r_valid), 32'd0);
    chk("rst_q_ready", 32'(q_ready), 32'd1);
    chk("rst_r_kind", 32'(r_kind), 32'd0);
    chk("rst_r_data", r_data, 32'd0);
    chk("rst_r_last", 32'(r_last), 32'd0);
    chk("rst_r_error", 32'(r_error), 32'd0);

    query(2, 0, -1);

    do_count(1, 3);
    do_write(1, 0, 32'hA1);
    do_write(1, 1, 32'hB2);
    do_write(1, 2, 32'hC3);
    query(1, 0, -1);
    query(1, 1, -1);

    query(7, 0, -1);
    do_count(0, 20);
    query(0, 0, -1);

    query(1, 0, 2);
    query(1, 0, -1);

    // reset while a field beat is stalled
    build_exp(1);
    q_valid = 1'b1;
    q_class = 8'd1;
    @(negedge clk);
    q_valid = 1'b0;
    chk("abort_hdr_valid", 32'(r_valid), 32'd1);
    r_ready = 1'b1;
    @(negedge clk);
    r_ready = 1'b0;
    chk("abort_fld_kind", 32'(r_kind), 32'd1);
    chk("abort_fld_data", r_data, exp_q[1].d);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    model_clear();
    chk("abort_r_valid", 32'(r_valid), 32'd0);
    chk("abort_q_ready", 32'(q_ready), 32'd1);
    @(negedge clk);
    query(1, 0, -1);

    for (int it = 0; it < 60; it++) begin
      int op;
      op = $urandom_range(0, 3);
      if (op == 0) begin
        do_write($urandom_range(0, 5), $urandom_range(0, 9), $urandom);
      end else if (op == 1) begin
        do_count($urandom_range(0, 5), $urandom_range(0, 12));
      end else if (op == 2) begin
        int c;
        int f;
        int v;
        logic [31:0] n;
        c = $urandom_range(0, 4);
        f = $urandom_range(0, 8);
        v = $urandom_range(0, 10);
        n = $urandom;
        wr_en = 1'b1;
        cnt_wr_en = 1'b1;
        wr_class = 8'(c);
        wr_field = 8'(f);
        wr_name = n;
        cnt_wr_val = 8'(v);
        @(negedge clk);
        wr_en = 1'b0;
        cnt_wr_en = 1'b0;
        set_name(c, f, n);
        set_cnt(c, v);
      end else begin
        query($urandom_range(0, 5), 2, -1);
      end
    end
    for (int c = 0; c < 5; c++) query(c, 2, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
